// File: rtl/requant_ctrl_pkg.sv
// requant_ctrl_pkg
// Shared definitions for the int8 post-processing blocks:
//   REQ_MULT_W / REQ_SHIFT_W / OUT_W - datapath widths
//   req_entry_t                      - per-channel {mult, shift} table entry
//   rdbpot(x, r)                     - rounding divide by 2^r, half away from zero
package requant_ctrl_pkg;

  localparam int unsigned REQ_MULT_W  = 32;
  localparam int unsigned REQ_SHIFT_W = 6;
  localparam int unsigned OUT_W       = 8;

  typedef struct packed {
    logic signed [REQ_MULT_W-1:0]  mult;
    logic signed [REQ_SHIFT_W-1:0] shift;
  } req_entry_t;

  // Arithmetic shift floors toward -inf; the threshold gets +1 for negative
  // x so that exact halves still round away from zero.
  function automatic logic signed [31:0] rdbpot(input logic signed [31:0] x,
                                                input logic [4:0]         r);
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [31:0] q;
    mask = (32'd1 << r) - 32'd1;
    rem  = x & mask;
    thr  = (mask >> 1) + {31'd0, x[31]};
    q    = x >>> r;
    return q + {31'd0, (rem > thr)};
  endfunction

endpackage

// File: rtl/requant_ctrl_srdhm.sv
// requant_ctrl_srdhm
// Saturating rounding doubling high multiply (combinational).
//   a, b : signed 32-bit operands (b is Q0.31)
//   y    : 0x7fffffff when a == b == 0x80000000, else
//          (a*b +/- 2^30) / 2^31 truncated toward zero
module requant_ctrl_srdhm
  import requant_ctrl_pkg::*;
(
  input  logic signed [REQ_MULT_W-1:0] a,
  input  logic signed [REQ_MULT_W-1:0] b,
  output logic signed [REQ_MULT_W-1:0] y
);

  logic               sat;
  logic signed [63:0] ab;
  logic signed [63:0] sum;
  logic signed [63:0] adj;

  always_comb begin
    sat = (a == 32'sh8000_0000) && (b == 32'sh8000_0000);
    ab  = a * b;
    sum = ab + (ab[63] ? -64'sd1073741824 : 64'sd1073741824);
    // Bias negatives by 2^31-1 so the arithmetic shift truncates toward zero.
    adj = sum + (sum[63] ? 64'sd2147483647 : 64'sd0);
    y   = sat ? 32'sh7fff_ffff : 32'(adj >>> 31);
  end

endmodule

// File: rtl/requant_ctrl.sv
// requant_ctrl
// Streaming requantization: int32 accumulator + channel -> int8 result.
// Pipeline: S1 table lookup + left shift, S2 SRDHM, S3 rdbpot/offset/clamp.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   cfg_we/cfg_addr/cfg_mult/cfg_shift - per-channel table write
//   out_offset, act_min, act_max     - static zero-point and clamp bounds
//   in_valid/in_ready/in_acc/in_ch/in_last     - input stream
//   out_valid/out_ready/out_data/out_last      - output stream
//   busy                             - any stage holds a beat
module requant_ctrl
  import requant_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 256,
  parameter int unsigned CH_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [REQ_MULT_W-1:0]  cfg_mult,
  input  logic [REQ_SHIFT_W-1:0] cfg_shift,
  input  logic [31:0]            out_offset,
  input  logic [OUT_W-1:0]       act_min,
  input  logic [OUT_W-1:0]       act_max,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_acc,
  input  logic [CH_W-1:0]        in_ch,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy
);

  req_entry_t tbl [NUM_CH];

  // Stage registers
  logic                         v1, v2, v3;
  logic signed [REQ_MULT_W-1:0] x1_q, m1_q, x2_q;
  logic [4:0]                   r1_q, r2_q;
  logic                         l1_q, l2_q;
  logic [OUT_W-1:0]             od_q;
  logic                         ol_q;

  logic adv;
  logic accept;

  // Stage-1 combinational
  req_entry_t       ent;
  logic [5:0]       neg;
  logic [4:0]       lsh;
  logic [4:0]       rsh;
  logic [31:0]      x1_d;

  // Stage-2 / stage-3 combinational
  logic signed [REQ_MULT_W-1:0] x2_d;
  logic signed [31:0]           y3;
  logic signed [32:0]           z3;
  logic signed [32:0]           lo3;
  logic signed [32:0]           hi3;
  logic [OUT_W-1:0]             o3;

  assign adv      = !(v3 && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign busy     = v1 || v2 || v3;
  assign out_valid = v3;
  assign out_data  = od_q;
  assign out_last  = ol_q;

  // Table is plain flops without reset; a same-edge write is not seen by
  // the beat accepted on that edge since the read below is combinational.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl[cfg_addr] <= '{mult: cfg_mult, shift: cfg_shift};
    end
  end

  always_comb begin
    ent = tbl[in_ch];
    neg = 6'd0 - ent.shift;
    lsh = '0;
    rsh = '0;
    if (!ent.shift[5]) begin
      lsh = ent.shift[4:0];
    end else if (neg[5]) begin
      rsh = '1;          // shift of -32 saturates to a right shift of 31
    end else begin
      rsh = neg[4:0];
    end
    x1_d = in_acc << lsh;
  end

  requant_ctrl_srdhm u_srdhm (
    .a (x1_q),
    .b (m1_q),
    .y (x2_d)
  );

  always_comb begin
    y3  = rdbpot(x2_q, r2_q);
    z3  = {y3[31], y3} + {out_offset[31], out_offset};
    lo3 = 33'(signed'(act_min));
    hi3 = 33'(signed'(act_max));
    o3  = z3[OUT_W-1:0];
    if (z3 < lo3) begin
      o3 = act_min;
    end else if (z3 > hi3) begin
      o3 = act_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      x1_q <= '0;
      m1_q <= '0;
      r1_q <= '0;
      l1_q <= 1'b0;
      x2_q <= '0;
      r2_q <= '0;
      l2_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
    end else if (adv) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) begin
        x1_q <= x1_d;
        m1_q <= ent.mult;
        r1_q <= rsh;
        l1_q <= in_last;
      end
      if (v1) begin
        x2_q <= x2_d;
        r2_q <= r1_q;
        l2_q <= l1_q;
      end
      if (v2) begin
        od_q <= o3;
        ol_q <= l2_q;
      end
    end
  end

endmodule

// File: tb/tb_requant_ctrl.sv
module tb_requant_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_mult;
  logic [5:0]  cfg_shift;
  logic [31:0] out_offset;
  logic [7:0]  act_min;
  logic [7:0]  act_max;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic [7:0]  in_ch;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  requant_ctrl #(.NUM_CH(256), .CH_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .out_offset (out_offset),
    .act_min    (act_min),
    .act_max    (act_max),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_acc     (in_acc),
    .in_ch      (in_ch),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int ch, input logic [31:0] m, input logic [5:0] s);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = ch[7:0]; cfg_mult = m; cfg_shift = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One isolated beat: checks latency (accept edge counts as 1) and value.
  task automatic single(input string tag, input logic [31:0] acc, input int ch,
                        input int exp);
    int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_acc = acc; in_ch = ch[7:0]; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk(tag, $signed(out_data), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, got, cyc, stale;
    logic fire_in, fire_out;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mult = '0; cfg_shift = '0;
    out_offset = 32'hffff_ff80; act_min = 8'h80; act_max = 8'h7f;
    in_valid = 1'b0; in_acc = '0; in_ch = '0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    cfg(0, 32'h4000_0000, 6'd0);
    cfg(1, 32'h8000_0000, 6'd0);
    cfg(2, 32'h7fff_ffff, 6'h3e);   // -2
    cfg(3, 32'h4000_0000, 6'd3);
    cfg(4, 32'h4000_0000, 6'd0);

    single("ch0_100", 32'd100, 0, -78);
    out_offset = 32'd0;
    single("ch1_sat", 32'h8000_0000, 1, 127);
    single("ch2_neg", 32'hffff_fff6, 2, -3);
    single("ch2_pos", 32'd10, 2, 3);
    single("ch3_shl", 32'd5, 3, 20);
    single("ch3_wrap", 32'h2000_0000, 3, 0);

    // Write ch4 on the same edge a ch4 beat is accepted: old 0.5 applies
    // (100 -> 50); the next beat sees the new ~1.0 multiplier (100 -> 100).
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 8'd4; cfg_mult = 32'h7fff_ffff; cfg_shift = 6'd0;
    in_valid = 1'b1; in_acc = 32'd100; in_ch = 8'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_old_v", out_valid, 1);
    chk("wr_old", $signed(out_data), 50);
    @(posedge clk); #1;
    chk("wr_new_v", out_valid, 1);
    chk("wr_new", $signed(out_data), 100);
    @(posedge clk); #1;

    // 16-beat stream on ch0 with offset -128: acc 20*i -> 10*i - 128.
    out_offset = 32'hffff_ff80;
    sent = 0; got = 0; cyc = 0;
    while ((sent < 16 || got < 16) && cyc < 400) begin
      @(negedge clk);
      out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 16);
      in_acc    = 32'(20 * sent);
      in_ch     = 8'd0;
      in_last   = (sent == 15);
      #3;
      chk("stall_rdy", in_ready, !(out_valid && !out_ready));
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        chk("stream_data", $signed(out_data), 10 * got - 128);
        chk("stream_last", out_last, (got == 15));
        got++;
      end
      @(posedge clk);
      if (fire_in) sent++;
      cyc++;
    end
    chk("stream_done", got, 16);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Three beats in flight, then asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; in_acc = 32'd100; in_ch = 8'd0;
    repeat (3) @(posedge clk);
    #2 in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_rdy", in_ready, 1);
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    chk("no_stale", stale, 0);
    single("post_rst_ch0", 32'd100, 0, -78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
